// File: rtl/csv_useq_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : csv_useq_ctrl_pkg                                         |
// | Brief  : Shared constants for the microsequencer / PC / jump-mux   |
// |          block: jump-select encoding, flag indices and microword   |
// |          field offsets of the ctrl_* signals.                      |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package csv_useq_ctrl_pkg;

   // Jump select 0 is the hard "never jump" selector; flag input 0 is ignored.
   localparam int JSEL_NEVER      = 0;

   // Flag input indices as wired from the ALU and UART status.
   localparam int FLAG_CARRY       = 1;
   localparam int FLAG_OVF         = 2;
   localparam int FLAG_ZERO        = 3;
   localparam int FLAG_NEG         = 4;
   localparam int FLAG_DIVZ        = 5;
   localparam int FLAG_UART_TX_RDY = 6;
   localparam int FLAG_UART_RX_VLD = 7;

   // Bit offsets of each control field inside the decode-ROM microword.
   localparam int UW_URESET_N_BIT = 0;
   localparam int UW_PC_INCR_BIT  = 1;
   localparam int UW_JSEL_LSB     = 2;
   localparam int UW_JSEL_MSB     = 4;
   localparam int UW_IR_LOAD_BIT  = 5;
   localparam int UW_MEM_WAIT_BIT = 6;

endpackage
`default_nettype wire

// File: rtl/csv_jump_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : csv_jump_mux                                              |
// | Brief  : Combinational jump-condition select. Selector 0 never     |
// |          jumps; selectors at or beyond NFLAGS never jump.          |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module csv_jump_mux
   import csv_useq_ctrl_pkg::*;
#(
   parameter int NFLAGS = 8,
   parameter int JSEL_W = 3      // 2**JSEL_W must be >= NFLAGS
) (
   input  logic [JSEL_W-1:0] jsel_i,
   input  logic [NFLAGS-1:0] flags_i,
   output logic              taken_o
);

   // Flag 0 sits behind the "never" selector and is deliberately not read.
   logic unused_flag_never;
   assign unused_flag_never = flags_i[JSEL_NEVER];

   // Pick the addressed flag; unmatched selectors fall through to not-taken.
   always_comb begin
      taken_o = 1'b0;
      for (int k = JSEL_NEVER + 1; k < NFLAGS; k++) begin
         if (int'(jsel_i) == k) begin
            taken_o = flags_i[k];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/csv_useq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : csv_useq_ctrl                                             |
// | Brief  : Instruction register, microstep counter and program       |
// |          counter with conditional jump, memory wait-state stall,   |
// |          run/single-step freeze and microstep overflow pulse.      |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module csv_useq_ctrl
   import csv_useq_ctrl_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int IR_W   = 8,
   parameter int USEQ_W = 4,
   parameter int NFLAGS = 8,
   parameter int JSEL_W = 3
) (
   input  logic                   i_clk,
   input  logic                   reset,
   input  logic                   run_en,
   input  logic                   step,
   input  logic                   ctrl_ureset_n,
   input  logic                   ctrl_pc_incr,
   input  logic [JSEL_W-1:0]      ctrl_jsel,
   input  logic                   ctrl_ir_load,
   input  logic                   ctrl_mem_wait,
   input  logic                   mem_ready,
   input  logic [NFLAGS-1:0]      flags,
   input  logic [ADDR_W-1:0]      ar_in,
   input  logic [IR_W-1:0]        data_in,
   output logic [IR_W+USEQ_W-1:0] decode_idx,
   output logic [ADDR_W-1:0]      pc,
   output logic                   stall,
   output logic                   ustep_ovf
);

   logic [IR_W-1:0]   ir_q,    ir_d;
   logic [USEQ_W-1:0] ustep_q, ustep_d;
   logic [ADDR_W-1:0] pc_q,    pc_d;
   logic              ovf_q,   ovf_d;

   logic              adv_w;
   logic              commit_w;
   logic              taken_w;

   csv_jump_mux #(
      .NFLAGS (NFLAGS),
      .JSEL_W (JSEL_W)
   ) u_jump_mux (
      .jsel_i  (ctrl_jsel),
      .flags_i (flags),
      .taken_o (taken_w)
   );

   // A microstep retires only when advancing is allowed and memory is not holding us.
   always_comb begin
      adv_w    = run_en | step;
      stall    = ctrl_mem_wait & ~mem_ready;
      commit_w = adv_w & ~stall;
   end

   // Next-state for IR, microstep, PC and the overflow pulse; everything holds without a commit.
   always_comb begin
      ir_d    = ir_q;
      ustep_d = ustep_q;
      pc_d    = pc_q;
      ovf_d   = 1'b0;
      if (commit_w) begin
         ustep_d = ctrl_ureset_n ? (ustep_q + USEQ_W'(1)) : '0;
         ovf_d   = ctrl_ureset_n & (&ustep_q);
         // Jump wins over increment; increment wraps naturally at the register width.
         pc_d    = taken_w ? ar_in : (pc_q + ADDR_W'(ctrl_pc_incr));
         if (ctrl_ir_load) begin
            ir_d = data_in;
         end
      end
   end

   // State registers with synchronous reset abandoning any in-flight instruction.
   always_ff @(posedge i_clk) begin
      if (reset) begin
         ir_q    <= '0;
         ustep_q <= '0;
         pc_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         ir_q    <= ir_d;
         ustep_q <= ustep_d;
         pc_q    <= pc_d;
         ovf_q   <= ovf_d;
      end
   end

   // The decode-ROM index is straight from the registers, so a new microword shows one cycle after commit.
   always_comb begin
      decode_idx = {ir_q, ustep_q};
      pc         = pc_q;
      ustep_ovf  = ovf_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_csv_useq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_csv_useq_ctrl                                          |
// | Brief  : Self-checking bench for csv_useq_ctrl: directed vector    |
// |          table, hand-written corner sequences, randomized run      |
// |          against an arithmetic reference model.                    |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_csv_useq_ctrl;

   logic        i_clk;
   logic        reset;
   logic        run_en;
   logic        step;
   logic        ctrl_ureset_n;
   logic        ctrl_pc_incr;
   logic [2:0]  ctrl_jsel;
   logic        ctrl_ir_load;
   logic        ctrl_mem_wait;
   logic        mem_ready;
   logic [7:0]  flags;
   logic [15:0] ar_in;
   logic [7:0]  data_in;
   logic [11:0] decode_idx;
   logic [15:0] pc;
   logic        stall;
   logic        ustep_ovf;

   int n_pass  = 0;
   int n_total = 0;

   csv_useq_ctrl #(
      .ADDR_W (16),
      .IR_W   (8),
      .USEQ_W (4),
      .NFLAGS (8),
      .JSEL_W (3)
   ) dut (
      .i_clk         (i_clk),
      .reset         (reset),
      .run_en        (run_en),
      .step          (step),
      .ctrl_ureset_n (ctrl_ureset_n),
      .ctrl_pc_incr  (ctrl_pc_incr),
      .ctrl_jsel     (ctrl_jsel),
      .ctrl_ir_load  (ctrl_ir_load),
      .ctrl_mem_wait (ctrl_mem_wait),
      .mem_ready     (mem_ready),
      .flags         (flags),
      .ar_in         (ar_in),
      .data_in       (data_in),
      .decode_idx    (decode_idx),
      .pc            (pc),
      .stall         (stall),
      .ustep_ovf     (ustep_ovf)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   typedef struct {
      logic        rst, run, stp, urn, inc;
      logic [2:0]  js;
      logic        irl, mw, mr;
      logic [7:0]  fl;
      logic [15:0] ar;
      logic [7:0]  din;
      logic [15:0] epc;
      logic [11:0] eidx;
      logic        est, eovf;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; run_en = 1'b0; step = 1'b0; ctrl_ureset_n = 1'b1;
      ctrl_pc_incr = 1'b0; ctrl_jsel = 3'd0; ctrl_ir_load = 1'b0;
      ctrl_mem_wait = 1'b0; mem_ready = 1'b0; flags = 8'h00;
      ar_in = 16'h0000; data_in = 8'h00;
   endtask

   task automatic apply(input vec_t v, input int n);
      reset = v.rst; run_en = v.run; step = v.stp; ctrl_ureset_n = v.urn;
      ctrl_pc_incr = v.inc; ctrl_jsel = v.js; ctrl_ir_load = v.irl;
      ctrl_mem_wait = v.mw; mem_ready = v.mr; flags = v.fl;
      ar_in = v.ar; data_in = v.din;
      #1;
      chk($sformatf("vec%0d stall", n), 32'(stall), 32'(v.est));
      @(posedge i_clk);
      #1;
      chk($sformatf("vec%0d pc", n), 32'(pc), 32'(v.epc));
      chk($sformatf("vec%0d decode_idx", n), 32'(decode_idx), 32'(v.eidx));
      chk($sformatf("vec%0d ustep_ovf", n), 32'(ustep_ovf), 32'(v.eovf));
   endtask

   // reference model state
   int m_pc, m_ir, m_us, m_ovf;

   initial begin
      int pulses;
      bit m_commit, m_taken, m_stall;

      idle();
      //             rst   run   stp   urn   inc   js    irl   mw    mr    fl     ar        din      epc       eidx     est   eovf
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 16'h0000, 12'h000, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 16'h0000, 12'h000, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h3C, 16'h0001, 12'h3C1, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'h08, 16'h8123, 8'h00, 16'h8123, 12'h3C2, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 16'h8123, 8'h00, 16'h8124, 12'h3C3, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'hFF, 16'h1234, 8'h00, 16'h8125, 12'h3C4, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 8'h80, 16'h0400, 8'h00, 16'h0400, 12'h3C5, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 16'h0400, 12'h3C0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h55, 16'h0400, 12'h3C0, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h55, 16'h0400, 12'h3C0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h55, 16'h0400, 12'h3C0, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 8'h00, 16'h0000, 8'h00, 16'h0401, 12'h3C1, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 8'hFF, 16'h7777, 8'hAA, 16'h0401, 12'h3C1, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 16'h0402, 12'h3C2, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h00, 16'h0402, 12'h3C2, 1'b1, 1'b0};
      tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00, 16'h0000, 12'h000, 1'b0, 1'b0};

      for (int i = 0; i < 16; i++) apply(tbl[i], i);

      // Microstep wrap: 16 commits from ustep 0 give exactly one overflow pulse on the last.
      idle();
      run_en = 1'b1;
      pulses = 0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (ustep_ovf) pulses++;
         if (i == 15) begin
            chk("wrap idx at F", 32'(decode_idx), 32'h00F);
            chk("wrap no ovf at F", 32'(ustep_ovf), 32'h0);
         end
      end
      chk("wrap idx at 0", 32'(decode_idx), 32'h000);
      chk("wrap ovf pulse", 32'(ustep_ovf), 32'h1);
      ctrl_ureset_n = 1'b0;
      tick();
      chk("ovf one cycle", 32'(ustep_ovf), 32'h0);
      chk("ovf pulse count", 32'(pulses), 32'h1);

      // PC wrap: jump to FFFF then increment.
      ctrl_ureset_n = 1'b1; ctrl_jsel = 3'd1; flags = 8'h02; ar_in = 16'hFFFF; ctrl_pc_incr = 1'b1;
      tick();
      chk("pc jump FFFF", 32'(pc), 32'hFFFF);
      ctrl_jsel = 3'd0; flags = 8'h00;
      tick();
      chk("pc wrap 0000", 32'(pc), 32'h0000);
      chk("pc wrap idx", 32'(decode_idx), 32'h002);

      // Freeze: five idle cycles, then a single step pulse.
      run_en = 1'b0; step = 1'b0; ctrl_ir_load = 1'b1; data_in = 8'h5A;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("freeze%0d pc", i), 32'(pc), 32'h0000);
         chk($sformatf("freeze%0d idx", i), 32'(decode_idx), 32'h002);
      end
      step = 1'b1;
      tick();
      chk("step pc", 32'(pc), 32'h0001);
      chk("step idx", 32'(decode_idx), 32'h5A3);
      step = 1'b0;
      tick();
      chk("after step pc", 32'(pc), 32'h0001);
      chk("after step idx", 32'(decode_idx), 32'h5A3);
      run_en = 1'b1; step = 1'b1; ctrl_ir_load = 1'b0;
      tick();
      chk("run+step pc", 32'(pc), 32'h0002);
      chk("run+step idx", 32'(decode_idx), 32'h5A4);

      // Reset landing in the middle of a stall.
      step = 1'b0; ctrl_mem_wait = 1'b1; mem_ready = 1'b0;
      tick();
      tick();
      chk("stall held", 32'(stall), 32'h1);
      chk("stall pc frozen", 32'(pc), 32'h0002);
      reset = 1'b1;
      tick();
      chk("reset in stall pc", 32'(pc), 32'h0000);
      chk("reset in stall idx", 32'(decode_idx), 32'h000);

      // Randomized run against the reference model.
      idle();
      reset = 1'b1;
      tick();
      m_pc = 0; m_ir = 0; m_us = 0; m_ovf = 0;
      for (int n = 0; n < 600; n++) begin
         reset         = ($urandom_range(0, 31) == 0);
         run_en        = ($urandom_range(0, 3) != 0);
         step          = 1'($urandom_range(0, 1));
         ctrl_ureset_n = ($urandom_range(0, 7) != 0);
         ctrl_pc_incr  = 1'($urandom_range(0, 1));
         ctrl_jsel     = 3'($urandom_range(0, 7));
         ctrl_ir_load  = 1'($urandom_range(0, 1));
         ctrl_mem_wait = ($urandom_range(0, 2) == 0);
         mem_ready     = 1'($urandom_range(0, 1));
         flags         = 8'($urandom);
         ar_in         = 16'($urandom);
         data_in       = 8'($urandom);
         #1;
         m_stall = ctrl_mem_wait && !mem_ready;
         chk("rand stall", 32'(stall), 32'(m_stall));
         m_commit = (run_en || step) && !m_stall;
         m_taken  = (ctrl_jsel != 3'd0) && flags[ctrl_jsel];
         if (reset) begin
            m_pc = 0; m_ir = 0; m_us = 0; m_ovf = 0;
         end else if (m_commit) begin
            m_ovf = (ctrl_ureset_n && m_us == 15) ? 1 : 0;
            m_us  = ctrl_ureset_n ? (m_us + 1) % 16 : 0;
            m_pc  = m_taken ? int'(ar_in) : (m_pc + int'(ctrl_pc_incr)) % 65536;
            if (ctrl_ir_load) m_ir = int'(data_in);
         end else begin
            m_ovf = 0;
         end
         tick();
         chk("rand pc", 32'(pc), 32'(m_pc));
         chk("rand decode_idx", 32'(decode_idx), 32'(m_ir * 16 + m_us));
         chk("rand ustep_ovf", 32'(ustep_ovf), 32'(m_ovf));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
